// File: rtl/line_clear_engine.sv
// Line-clear engine: on each piece lock, scans the playfield bottom-up, compacts the
// surviving rows downward, zero-fills the freed top rows and updates score/lines/level.
module line_clear_engine #(
    parameter int ROWS      = 20,
    parameter int COLS      = 10,
    parameter int CELL_W    = 5,
    parameter int SCORE_MAX = 999999,
    parameter int LINES_MAX = 999
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear_score,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             rd_row,
    input  logic [COLS*CELL_W-1:0] rd_data,
    output logic                   wr_en,
    output logic [4:0]             wr_row,
    output logic [COLS*CELL_W-1:0] wr_data,
    output logic [4:0]             lines_cleared,
    output logic [19:0]            score,
    output logic [9:0]             total_lines,
    output logic [3:0]             level
);

    typedef enum logic [2:0] {IDLE, RD, CHK, FILL, SCORE, DONE} state_t;

    localparam logic [20:0] SCORE_CAP = 21'(SCORE_MAX);
    localparam logic [10:0] LINES_CAP = 11'(LINES_MAX);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    state_t      state_q, state_d;
    logic [4:0]  src_q, src_d;
    logic [4:0]  dst_q, dst_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  lines_q;
    logic [19:0] score_q;
    logic [9:0]  total_q;
    logic [3:0]  level_q;

    logic        rowFull;
    logic [15:0] pts;
    logic [15:0] levelMul;
    logic [15:0] product;
    logic [20:0] scoreSum;
    logic [19:0] scoreNew;
    logic [10:0] totalSum;
    logic [9:0]  totalNew;
    logic [9:0]  levelRaw;
    logic [3:0]  levelNew;

    // A row is full only when every cell holds a nonzero code.
    always_comb begin
        rowFull = 1'b1;
        for (int j = 0; j < COLS; j++) begin
            if (rd_data[j*CELL_W +: CELL_W] == '0) begin
                rowFull = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD;
            RD:      state_d = CHK;
            CHK: begin
                if (src_q == '0) begin
                    state_d = (cnt_d != '0) ? FILL : SCORE;
                end else begin
                    state_d = RD;
                end
            end
            FILL:    if (dst_q == '0) state_d = SCORE;
            SCORE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // After the scan dst sits at cnt-1, so FILL walks dst down to row 0: exactly cnt writes.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = LAST_ROW;
                    dst_d = LAST_ROW;
                    cnt_d = '0;
                end
            end
            CHK: begin
                if (rowFull) begin
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    dst_d = dst_q - 5'd1;
                end
                if (src_q != '0) begin
                    src_d = src_q - 5'd1;
                end
            end
            FILL:    dst_d = dst_q - 5'd1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    // Points use the level held before this operation's lines are added.
    always_comb begin
        case (cnt_q)
            5'd0:    pts = 16'd0;
            5'd1:    pts = 16'd40;
            5'd2:    pts = 16'd100;
            5'd3:    pts = 16'd300;
            default: pts = 16'd1200;
        endcase
        levelMul = {12'd0, level_q} + 16'd1;
        product  = pts * levelMul;
        scoreSum = {1'b0, score_q} + {5'd0, product};
        scoreNew = (scoreSum > SCORE_CAP) ? SCORE_CAP[19:0] : scoreSum[19:0];
        totalSum = {1'b0, total_q} + {6'd0, cnt_q};
        totalNew = (totalSum > LINES_CAP) ? LINES_CAP[9:0] : totalSum[9:0];
        levelRaw = totalNew / 10'd10;
        levelNew = (levelRaw > 10'd15) ? 4'd15 : levelRaw[3:0];
    end

    // A new-game clear overrides any score update landing in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            lines_q <= '0;
            score_q <= '0;
            total_q <= '0;
            level_q <= '0;
        end else begin
            if (state_q == SCORE) begin
                lines_q <= cnt_q;
            end
            if (clear_score) begin
                score_q <= '0;
                total_q <= '0;
                level_q <= '0;
            end else if (state_q == SCORE) begin
                score_q <= scoreNew;
                total_q <= totalNew;
                level_q <= levelNew;
            end
        end
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        rd_row  = (state_q == RD) ? src_q : 5'd0;
        wr_en   = 1'b0;
        wr_row  = 5'd0;
        wr_data = '0;
        case (state_q)
            CHK: begin
                if (!rowFull && (src_q != dst_q)) begin
                    wr_en   = 1'b1;
                    wr_row  = dst_q;
                    wr_data = rd_data;
                end
            end
            FILL: begin
                wr_en  = 1'b1;
                wr_row = dst_q;
            end
            default: ;
        endcase
    end

    assign lines_cleared = lines_q;
    assign score         = score_q;
    assign total_lines   = total_q;
    assign level         = level_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: a behavioural 20x10 map with synchronous read
// sits on the engine's ports and final map rows and counters are compared to hand values.
module tb_line_clear_engine;

    localparam logic [49:0] FULL_ROW = {10{5'd1}};
    localparam logic [49:0] PAT_A    = 50'd3;
    localparam logic [49:0] PAT_B    = (50'd7 << 45) | (50'd5 << 10);

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic        clearScore;
    logic        busy;
    logic        done;
    logic [4:0]  rdRow;
    logic [49:0] rdData;
    logic        wrEn;
    logic [4:0]  wrRow;
    logic [49:0] wrData;
    logic [4:0]  linesCleared;
    logic [19:0] score;
    logic [9:0]  totalLines;
    logic [3:0]  level;

    logic [49:0] mapMem [20];
    logic        tbWe;
    logic [4:0]  tbRow;
    logic [49:0] tbData;

    int checks = 0;
    int errors = 0;
    int doneAt, writes, doneCount;

    line_clear_engine dut (
        .CLOCK_50      (clk),
        .rst_n         (rstN),
        .start         (start),
        .clear_score   (clearScore),
        .busy          (busy),
        .done          (done),
        .rd_row        (rdRow),
        .rd_data       (rdData),
        .wr_en         (wrEn),
        .wr_row        (wrRow),
        .wr_data       (wrData),
        .lines_cleared (linesCleared),
        .score         (score),
        .total_lines   (totalLines),
        .level         (level)
    );

    always #10 clk = ~clk;

    // Playfield RAM with one-cycle read latency; the bench loads it only while the engine is idle.
    always @(posedge clk) begin
        rdData <= mapMem[rdRow];
        if (wrEn) begin
            mapMem[wrRow] <= wrData;
        end else if (tbWe) begin
            mapMem[tbRow] <= tbData;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeRow(input int r, input logic [49:0] d);
        @(negedge clk);
        tbWe   = 1'b1;
        tbRow  = 5'(r);
        tbData = d;
        @(negedge clk);
        tbWe   = 1'b0;
    endtask

    task automatic clearMap();
        for (int r = 0; r < 20; r++) begin
            writeRow(r, 50'd0);
        end
    endtask

    task automatic loadTetris();
        clearMap();
        for (int r = 16; r < 20; r++) begin
            writeRow(r, FULL_ROW);
        end
    endtask

    // Pulses start, then samples each following cycle at the falling edge (k = cycles after start).
    task automatic applyStimulus(input int clearAt, input int restartAt,
                                 output int firstDone, output int wrCount, output int doneCnt);
        firstDone = -1;
        wrCount   = 0;
        doneCnt   = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            if (done) begin
                doneCnt++;
                if (firstDone < 0) firstDone = k;
            end
            if (wrEn) wrCount++;
            clearScore = (k == clearAt);
            start      = (k == restartAt);
            if (restartAt == 0 && firstDone > 0 && k > firstDone) break;
            @(negedge clk);
        end
        start      = 1'b0;
        clearScore = 1'b0;
    endtask

    initial begin
        rstN       = 1'b0;
        start      = 1'b0;
        clearScore = 1'b0;
        tbWe       = 1'b0;
        tbRow      = '0;
        tbData     = '0;
        #35;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset wr_en", 64'(wrEn), 64'd0);
        checkOutput("reset score", 64'(score), 64'd0);
        checkOutput("reset rd_row", 64'(rdRow), 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Empty map: pure scan, nothing moves.
        clearMap();
        applyStimulus(0, 0, doneAt, writes, doneCount);
        checkOutput("empty done cycle", 64'(doneAt), 64'd42);
        checkOutput("empty writes", 64'(writes), 64'd0);
        checkOutput("empty lines_cleared", 64'(linesCleared), 64'd0);
        checkOutput("empty score", 64'(score), 64'd0);

        // Single line: row 18 drops into row 19.
        clearMap();
        writeRow(19, FULL_ROW);
        writeRow(18, PAT_A);
        applyStimulus(0, 0, doneAt, writes, doneCount);
        checkOutput("single done cycle", 64'(doneAt), 64'd43);
        checkOutput("single writes", 64'(writes), 64'd20);
        checkOutput("single row19", 64'(mapMem[19]), 64'(PAT_A));
        checkOutput("single row0", 64'(mapMem[0]), 64'd0);
        checkOutput("single lines_cleared", 64'(linesCleared), 64'd1);
        checkOutput("single score", 64'(score), 64'd40);
        checkOutput("single total", 64'(totalLines), 64'd1);

        // Tetris at level 0 with markers in rows 15 and 0.
        loadTetris();
        writeRow(15, PAT_B);
        writeRow(0, PAT_A);
        applyStimulus(0, 0, doneAt, writes, doneCount);
        checkOutput("tetris done cycle", 64'(doneAt), 64'd46);
        checkOutput("tetris writes", 64'(writes), 64'd20);
        checkOutput("tetris row19", 64'(mapMem[19]), 64'(PAT_B));
        checkOutput("tetris row4", 64'(mapMem[4]), 64'(PAT_A));
        checkOutput("tetris row3", 64'(mapMem[3]), 64'd0);
        checkOutput("tetris row0", 64'(mapMem[0]), 64'd0);
        checkOutput("tetris lines_cleared", 64'(linesCleared), 64'd4);
        checkOutput("tetris score", 64'(score), 64'd1240);
        checkOutput("tetris total", 64'(totalLines), 64'd5);
        checkOutput("tetris level", 64'(level), 64'd0);

        // Two non-adjacent lines.
        clearMap();
        writeRow(19, FULL_ROW);
        writeRow(18, PAT_A);
        writeRow(17, FULL_ROW);
        writeRow(16, PAT_B);
        applyStimulus(0, 0, doneAt, writes, doneCount);
        checkOutput("split done cycle", 64'(doneAt), 64'd44);
        checkOutput("split row19", 64'(mapMem[19]), 64'(PAT_A));
        checkOutput("split row18", 64'(mapMem[18]), 64'(PAT_B));
        checkOutput("split row17", 64'(mapMem[17]), 64'd0);
        checkOutput("split row1", 64'(mapMem[1]), 64'd0);
        checkOutput("split lines_cleared", 64'(linesCleared), 64'd2);
        checkOutput("split score", 64'(score), 64'd1340);
        checkOutput("split total", 64'(totalLines), 64'd7);

        // Reset in the middle of FILL (cycle 42 of a tetris).
        loadTetris();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (41) @(negedge clk);
        checkOutput("midfill wr_en", 64'(wrEn), 64'd1);
        rstN = 1'b0;
        #1;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset wr_en", 64'(wrEn), 64'd0);
        checkOutput("midreset score", 64'(score), 64'd0);
        checkOutput("midreset total", 64'(totalLines), 64'd0);
        checkOutput("midreset lines_cleared", 64'(linesCleared), 64'd0);
        checkOutput("midreset wr_row", 64'(wrRow), 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Normal run after reset, with a second start pulsed while busy.
        clearMap();
        writeRow(19, FULL_ROW);
        writeRow(18, PAT_A);
        applyStimulus(0, 5, doneAt, writes, doneCount);
        checkOutput("restart done cycle", 64'(doneAt), 64'd43);
        checkOutput("restart done count", 64'(doneCount), 64'd1);
        checkOutput("restart row19", 64'(mapMem[19]), 64'(PAT_A));
        checkOutput("restart score", 64'(score), 64'd40);

        // New-game clear while idle leaves lines_cleared alone.
        @(negedge clk);
        clearScore = 1'b1;
        @(negedge clk);
        clearScore = 1'b0;
        checkOutput("clear score", 64'(score), 64'd0);
        checkOutput("clear total", 64'(totalLines), 64'd0);
        checkOutput("clear lines_cleared", 64'(linesCleared), 64'd1);

        // Eight tetrises climb through levels 0,0,0,1,1,2,2,2 -> 19200 points, 32 lines.
        for (int t = 0; t < 8; t++) begin
            loadTetris();
            applyStimulus(0, 0, doneAt, writes, doneCount);
        end
        checkOutput("eight score", 64'(score), 64'd19200);
        checkOutput("eight total", 64'(totalLines), 64'd32);
        checkOutput("eight level", 64'(level), 64'd3);

        // Keep going until score and total_lines both saturate.
        for (int t = 8; t < 260; t++) begin
            loadTetris();
            applyStimulus(0, 0, doneAt, writes, doneCount);
            checkOutput("sat done cycle", 64'(doneAt), 64'd46);
        end
        checkOutput("sat score", 64'(score), 64'd999999);
        checkOutput("sat total", 64'(totalLines), 64'd999);
        checkOutput("sat level", 64'(level), 64'd15);

        // Clear arriving in the SCORE cycle beats the update.
        loadTetris();
        applyStimulus(45, 0, doneAt, writes, doneCount);
        checkOutput("clear@score done cycle", 64'(doneAt), 64'd46);
        checkOutput("clear@score score", 64'(score), 64'd0);
        checkOutput("clear@score total", 64'(totalLines), 64'd0);
        checkOutput("clear@score level", 64'(level), 64'd0);
        checkOutput("clear@score lines_cleared", 64'(linesCleared), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
